// File: rtl/board_serial_tx.sv
// rtl/board_serial_tx.sv - framed serial transmitter for the board/location/error snapshot
// Optional feature macro: BOARD_TX_PARITY_EN (inserts an even-parity bit before stop)
module board_serial_tx #(
  parameter int BOARD_W = 32,
  parameter int LOC_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clka,
  input  logic               restart,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [LOC_W-1:0]   location,
  input  logic               error_in,
  input  logic               send,
  output logic               ser_data,
  output logic               ser_valid,
  input  logic               ser_ready,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [CNT_W-1:0]   frame_count
);

  // Bit counter must index the wider of the two multi-bit fields.
  localparam int FIELD_MAX = (BOARD_W > LOC_W) ? BOARD_W : LOC_W;
  localparam int BC_W      = (FIELD_MAX > 1) ? $clog2(FIELD_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BOARD = 3'd2,
    S_LOC   = 3'd3,
    S_ERR   = 3'd4,
`ifdef BOARD_TX_PARITY_EN
    S_PAR   = 3'd5,
`endif
    S_STOP  = 3'd6
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BC_W-1:0]    bit_cnt;
  logic [BOARD_W-1:0] shadow_board;
  logic [LOC_W-1:0]   shadow_loc;
  logic               shadow_err;
`ifdef BOARD_TX_PARITY_EN
  logic               shadow_par;
`endif

  logic snap;
  logic shift_board;
  logic shift_loc;
  logic stop_acc;

  // State register; restart aborts any frame in flight.
  always_ff @(posedge clka) begin
    if (restart) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and serial outputs; a bit advances only when the receiver takes it.
  always_comb begin
    state_next  = state;
    ser_valid   = 1'b1;
    ser_data    = 1'b1;
    busy        = 1'b1;
    snap        = 1'b0;
    shift_board = 1'b0;
    shift_loc   = 1'b0;
    stop_acc    = 1'b0;
    case (state)
      S_IDLE: begin
        ser_valid = 1'b0;
        busy      = 1'b0;
        if (send) begin
          snap       = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        ser_data = 1'b0;
        if (ser_ready) begin
          state_next = S_BOARD;
        end
      end
      S_BOARD: begin
        ser_data = shadow_board[BOARD_W-1];
        if (ser_ready) begin
          shift_board = 1'b1;
          if (bit_cnt == BC_W'(BOARD_W - 1)) begin
            state_next = S_LOC;
          end
        end
      end
      S_LOC: begin
        ser_data = shadow_loc[LOC_W-1];
        if (ser_ready) begin
          shift_loc = 1'b1;
          if (bit_cnt == BC_W'(LOC_W - 1)) begin
            state_next = S_ERR;
          end
        end
      end
      S_ERR: begin
        ser_data = shadow_err;
        if (ser_ready) begin
`ifdef BOARD_TX_PARITY_EN
          state_next = S_PAR;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef BOARD_TX_PARITY_EN
      S_PAR: begin
        ser_data = shadow_par;
        if (ser_ready) begin
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        ser_data = 1'b1;
        if (ser_ready) begin
          stop_acc   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        ser_valid  = 1'b0;
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Snapshot and shift the payload; fields go out MSB first from the top of each shadow.
  always_ff @(posedge clka) begin
    if (restart) begin
      shadow_board <= '0;
      shadow_loc   <= '0;
      shadow_err   <= 1'b0;
    end else if (snap) begin
      shadow_board <= board_in;
      shadow_loc   <= location;
      shadow_err   <= error_in;
    end else begin
      if (shift_board) begin
        shadow_board <= {shadow_board[BOARD_W-2:0], 1'b0};
      end
      if (shift_loc) begin
        shadow_loc <= {shadow_loc[LOC_W-2:0], 1'b0};
      end
    end
  end

`ifdef BOARD_TX_PARITY_EN
  // Parity is fixed at snapshot time so shifting the shadows cannot disturb it.
  always_ff @(posedge clka) begin
    if (restart) begin
      shadow_par <= 1'b0;
    end else if (snap) begin
      shadow_par <= ^{board_in, location, error_in};
    end
  end
`endif

  // Bit counter restarts on every state change so each field counts from zero.
  always_ff @(posedge clka) begin
    if (restart) begin
      bit_cnt <= '0;
    end else if (state_next != state) begin
      bit_cnt <= '0;
    end else if (shift_board || shift_loc) begin
      bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  // Completion pulse, frame counter and sticky overrun flag.
  always_ff @(posedge clka) begin
    if (restart) begin
      done        <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      done <= stop_acc;
      if (stop_acc) begin
        frame_count <= frame_count + CNT_W'(1);
      end
      if (send && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_serial_tx.sv
// tb/tb_board_serial_tx.sv - randomized self-checking bench for board_serial_tx
module tb_board_serial_tx;

`ifdef BOARD_TX_PARITY_EN
  localparam int FL = 41;
`else
  localparam int FL = 40;
`endif

  logic        clka = 1'b0;
  logic        restart;
  logic [31:0] board_in;
  logic [4:0]  location;
  logic        error_in;
  logic        send;
  logic        ser_data;
  logic        ser_valid;
  logic        ser_ready;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [7:0]  frame_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_frames = 0;
  logic model_ovr = 1'b0;

  board_serial_tx #(.BOARD_W(32), .LOC_W(5), .CNT_W(8)) dut (
    .clka        (clka),
    .restart     (restart),
    .board_in    (board_in),
    .location    (location),
    .error_in    (error_in),
    .send        (send),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .ser_ready   (ser_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole frame as one right-aligned word, first transmitted bit most significant.
  function automatic logic [63:0] ref_frame(input logic [31:0] b, input logic [4:0] l, input logic e);
`ifdef BOARD_TX_PARITY_EN
    logic p;
    p = ^{b, l, e};
    return {23'd0, 1'b0, b, l, e, p, 1'b1};
`else
    return {24'd0, 1'b0, b, l, e, 1'b1};
`endif
  endfunction

  task automatic do_reset();
    restart   = 1'b1;
    send      = 1'b1;
    ser_ready = 1'b1;
    repeat (2) @(posedge clka);
    @(negedge clka);
    check("rst_ser_data", 64'(ser_data), 64'd1);
    check("rst_ser_valid", 64'(ser_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    restart = 1'b0;
    send    = 1'b0;
    repeat (3) @(negedge clka);
    check("rst_no_frame_busy", 64'(busy), 64'd0);
    check("rst_no_frame_valid", 64'(ser_valid), 64'd0);
    model_frames = 0;
    model_ovr    = 1'b0;
  endtask

  // mode: 0 = ready always high, 1 = ready toggling, 2 = random ready.
  // inj >= 0: on that edge count, raise send and corrupt board_in while busy.
  task automatic run_frame(input logic [31:0] b, input logic [4:0] l, input logic e,
                           input int mode, input int inj);
    logic [63:0] got;
    logic [63:0] expf;
    int          nbits;
    int          edges;
    logic        pv, pr, pd, seen;
    got   = '0;
    nbits = 0;
    edges = 0;
    pv    = 1'b0;
    pr    = 1'b1;
    pd    = 1'b1;
    seen  = 1'b0;
    expf  = ref_frame(b, l, e);
    board_in  = b;
    location  = l;
    error_in  = e;
    send      = 1'b1;
    ser_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clka);
    #1 send = 1'b0;
    while (edges < 400) begin
      @(negedge clka);
      if (pv && !pr) begin
        check("hold_valid", 64'(ser_valid), 64'd1);
        check("hold_data", 64'(ser_data), 64'(pd));
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (ser_valid && ser_ready) begin
        got = {got[62:0], ser_data};
        nbits++;
      end
      pv = ser_valid;
      pr = ser_ready;
      pd = ser_data;
      @(posedge clka);
      edges++;
      #1;
      case (mode)
        0:       ser_ready = 1'b1;
        1:       ser_ready = ~ser_ready;
        default: ser_ready = 1'($urandom_range(0, 1));
      endcase
      if (edges == inj) begin
        board_in  = 32'hFFFF_FFFF;
        send      = 1'b1;
        model_ovr = 1'b1;
      end else begin
        send = 1'b0;
      end
    end
    send = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    if (seen) model_frames++;
    check("frame_bits", got, expf);
    check("frame_len", 64'(nbits), 64'(FL));
    if (mode == 0) check("latency", 64'(edges), 64'(FL));
    if (mode == 1) check("latency_bp", 64'(edges), 64'(2 * FL - 1));
    check("frame_count", 64'(frame_count), 64'(model_frames % 256));
    check("overrun", 64'(overrun), 64'(model_ovr));
    check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    logic dseen;
    restart   = 1'b1;
    board_in  = '0;
    location  = '0;
    error_in  = 1'b0;
    send      = 1'b0;
    ser_ready = 1'b1;

    do_reset();

    run_frame(32'hA5A5_0F0F, 5'd19, 1'b0, 0, -1);
    @(negedge clka);
    check("done_one_cycle", 64'(done), 64'd0);

    run_frame(32'hA5A5_0F0F, 5'd19, 1'b0, 1, -1);

    run_frame(32'hA5A5_0F0F, 5'd19, 1'b0, 0, 12);
    dseen = 1'b0;
    repeat (60) begin
      @(negedge clka);
      if (busy || done) dseen = 1'b1;
    end
    check("no_second_frame", 64'(dseen), 64'd0);
    check("overrun_frames", 64'(frame_count), 64'(model_frames % 256));

    do_reset();
    board_in  = 32'hA5A5_0F0F;
    location  = 5'd19;
    error_in  = 1'b0;
    ser_ready = 1'b1;
    send      = 1'b1;
    @(posedge clka);
    #1 send = 1'b0;
    repeat (10) @(posedge clka);
    @(negedge clka);
    check("abort_bit10", 64'(ser_data), 64'(board_in[22]));
    restart = 1'b1;
    @(posedge clka);
    #1 restart = 1'b0;
    @(negedge clka);
    check("abort_valid", 64'(ser_valid), 64'd0);
    check("abort_data", 64'(ser_data), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_count", 64'(frame_count), 64'd0);
    dseen = 1'b0;
    repeat (50) begin
      @(negedge clka);
      if (done) dseen = 1'b1;
    end
    check("abort_no_done", 64'(dseen), 64'd0);
    run_frame(32'hA5A5_0F0F, 5'd19, 1'b0, 0, -1);

    run_frame(32'h0000_0001, 5'd0, 1'b0, 0, -1);

    while (model_frames < 258) begin
      run_frame($urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 30)) : -1);
    end
    check("count_wrap", 64'(frame_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
